// File: rtl/riscv_mem_loader.sv
// riscv_mem_loader: boot loader and data-memory port arbiter for the RV32I core.
// It holds the core in reset while a host streams an image into data memory.
// Words are written to consecutive addresses starting at BASE_ADDR.
// It then releases the core and passes the core's memory port through.
// Optional feature macro: RISCV_LOADER_CHECKSUM_EN adds a CHECK state. CHECK
// compares the running sum of the loaded words against the host checksum.
module riscv_mem_loader #(
   parameter int unsigned       XLEN      = 32,
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       MAX_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           ld_start,
   input  logic [$clog2(MAX_WORDS):0]     ld_len,
   input  logic [XLEN-1:0]                ld_csum,
   input  logic                           ld_abort,
   input  logic                           ld_valid,
   input  logic [XLEN-1:0]                ld_data,
   output logic                           ld_ready,
   output logic                           ld_busy,
   output logic                           ld_done,
   output logic                           ld_error,
   output logic                           cpu_reset,
   input  logic                           cpu_MemWrite,
   input  logic [ADDR_W-1:0]              cpu_DataAdr,
   input  logic [XLEN-1:0]                cpu_WriteData,
   output logic                           MemWrite,
   output logic [ADDR_W-1:0]              DataAdr,
   output logic [XLEN-1:0]                WriteData
);

   localparam int unsigned      LEN_W   = $clog2(MAX_WORDS) + 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
`ifdef RISCV_LOADER_CHECKSUM_EN
      S_CHECK = 3'd2,
`endif
      S_RUN   = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             cpu_reset_q, busy_q, done_q, error_q;
   logic             xfer;
   logic             last_word;

`ifdef RISCV_LOADER_CHECKSUM_EN
   logic [XLEN-1:0]  sum_q, sum_d;
   logic [XLEN-1:0]  csum_q, csum_d;
`else
   // The checksum port exists in every build so the host wiring never changes.
   logic             unused_csum;
   assign unused_csum = ^ld_csum;
`endif

   // A word moves only in LOAD. Abort and reset both cancel the word in flight.
   assign xfer      = (state_q == S_LOAD) && ld_valid && !ld_abort && !reset;
   assign last_word = (count_q == (len_q - LEN_W'(1)));

   assign ld_ready  = (state_q == S_LOAD);
   assign ld_busy   = busy_q;
   assign ld_done   = done_q;
   assign ld_error  = error_q;
   assign cpu_reset = cpu_reset_q;

   // Next-state, word counter and session capture for the load sequencer
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      len_d   = len_q;
`ifdef RISCV_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (ld_start) begin
               if (ld_len == '0) begin
                  state_d = S_RUN;
               end else if (ld_len > MAX_LEN) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_LOAD;
                  len_d   = ld_len;
                  count_d = '0;
`ifdef RISCV_LOADER_CHECKSUM_EN
                  sum_d   = '0;
                  csum_d  = ld_csum;
`endif
               end
            end
         end
         S_LOAD: begin
            if (ld_abort) begin
               state_d = S_IDLE;
            end else if (ld_valid) begin
               count_d = count_q + LEN_W'(1);
`ifdef RISCV_LOADER_CHECKSUM_EN
               sum_d   = sum_q + ld_data;
               if (last_word) state_d = S_CHECK;
`else
               if (last_word) state_d = S_RUN;
`endif
            end
         end
`ifdef RISCV_LOADER_CHECKSUM_EN
         S_CHECK: state_d = (sum_q == csum_q) ? S_RUN : S_ERROR;
`endif
         S_RUN:   state_d = S_RUN;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase
   end

   // State register with status outputs registered from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         cpu_reset_q <= (state_d != S_RUN);
`ifdef RISCV_LOADER_CHECKSUM_EN
         busy_q      <= (state_d == S_LOAD) || (state_d == S_CHECK);
`else
         busy_q      <= (state_d == S_LOAD);
`endif
         done_q      <= (state_d == S_RUN);
         error_q     <= (state_d == S_ERROR);
      end
   end

   // Session length (and checksum values) are only meaningful while loading, so no reset
   always_ff @(posedge clk) begin
      len_q  <= len_d;
`ifdef RISCV_LOADER_CHECKSUM_EN
      sum_q  <= sum_d;
      csum_q <= csum_d;
`endif
   end

   // Memory port: core passthrough in RUN, loader word during a transfer, idle otherwise
   always_comb begin
      MemWrite  = 1'b0;
      DataAdr   = '0;
      WriteData = '0;
      if (state_q == S_RUN) begin
         MemWrite  = cpu_MemWrite && !reset;
         DataAdr   = cpu_DataAdr;
         WriteData = cpu_WriteData;
      end else if (xfer) begin
         MemWrite  = 1'b1;
         DataAdr   = BASE_ADDR + (ADDR_W'(count_q) << 2);
         WriteData = ld_data;
      end
   end

endmodule

// File: tb/tb_riscv_mem_loader.sv
// Scoreboard bench for riscv_mem_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_riscv_mem_loader;

   localparam int XLEN      = 32;
   localparam int ADDR_W    = 32;
   localparam int MAX_WORDS = 16;
   localparam int LEN_W     = $clog2(MAX_WORDS) + 1;

   logic              clk;
   logic              reset;
   logic              ld_start;
   logic [LEN_W-1:0]  ld_len;
   logic [XLEN-1:0]   ld_csum;
   logic              ld_abort;
   logic              ld_valid;
   logic [XLEN-1:0]   ld_data;
   logic              ld_ready, ld_busy, ld_done, ld_error, cpu_reset;
   logic              cpu_MemWrite;
   logic [ADDR_W-1:0] cpu_DataAdr;
   logic [XLEN-1:0]   cpu_WriteData;
   logic              MemWrite;
   logic [ADDR_W-1:0] DataAdr;
   logic [XLEN-1:0]   WriteData;

   riscv_mem_loader #(
      .XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .BASE_ADDR(32'h0)
   ) dut (
      .clk(clk), .reset(reset),
      .ld_start(ld_start), .ld_len(ld_len), .ld_csum(ld_csum), .ld_abort(ld_abort),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .ld_busy(ld_busy), .ld_done(ld_done), .ld_error(ld_error), .cpu_reset(cpu_reset),
      .cpu_MemWrite(cpu_MemWrite), .cpu_DataAdr(cpu_DataAdr), .cpu_WriteData(cpu_WriteData),
      .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every write seen on the memory port must match the oldest expected write
   always @(negedge clk) begin
      if (MemWrite !== 1'b0) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_write: got adr=0x%0h dat=0x%0h expected no write",
                     DataAdr, WriteData);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (MemWrite === 1'b1 && DataAdr === e.adr && WriteData === e.dat) n_pass++;
            else $display("FAIL mem_write: got we=%b adr=0x%0h dat=0x%0h expected adr=0x%0h dat=0x%0h",
                          MemWrite, DataAdr, WriteData, e.adr, e.dat);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ld_start = 1'b0; ld_len = '0; ld_csum = '0; ld_abort = 1'b0;
      ld_valid = 1'b0; ld_data = '0;
      cpu_MemWrite = 1'b0; cpu_DataAdr = '0; cpu_WriteData = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic start(input logic [LEN_W-1:0] len, input logic [31:0] csum);
      ld_start = 1'b1; ld_len = len; ld_csum = csum;
      step();
      ld_start = 1'b0;
   endtask

   task automatic send(input logic [31:0] data, input logic [31:0] adr);
      ld_valid = 1'b1; ld_data = data;
      exp_q.push_back('{adr: adr, dat: data});
      step();
      ld_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] sum;
      reset = 1'b1;
      ld_start = 1'b0; ld_len = '0; ld_csum = '0; ld_abort = 1'b0;
      ld_valid = 1'b0; ld_data = '0;
      cpu_MemWrite = 1'b0; cpu_DataAdr = '0; cpu_WriteData = '0;

      // Reset values
      do_reset();
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_ready", ld_ready, 0);
      check("rst_busy", ld_busy, 0);
      check("rst_done", ld_done, 0);
      check("rst_error", ld_error, 0);

      // Four back-to-back words
      start(4, 32'hAA);
      check("t1_ready", ld_ready, 1);
      check("t1_busy", ld_busy, 1);
      send(32'h11, 32'h0);
      send(32'h22, 32'h4);
      send(32'h33, 32'h8);
      send(32'h44, 32'hC);
`ifdef RISCV_LOADER_CHECKSUM_EN
      check("t1_check_cpu_reset", cpu_reset, 1);
      check("t1_check_busy", ld_busy, 1);
      step();
`endif
      check("t1_cpu_reset", cpu_reset, 0);
      check("t1_done", ld_done, 1);
      check("t1_busy_off", ld_busy, 0);

      // RUN passthrough; loader inputs are ignored
      check("run_ready", ld_ready, 0);
      cpu_MemWrite = 1'b1; cpu_DataAdr = 32'h40; cpu_WriteData = 32'hDEAD;
      ld_valid = 1'b1; ld_data = 32'h99; ld_start = 1'b1; ld_len = 5'd2; ld_abort = 1'b1;
      exp_q.push_back('{adr: 32'h40, dat: 32'hDEAD});
      step();
      cpu_MemWrite = 1'b0; ld_valid = 1'b0; ld_start = 1'b0; ld_abort = 1'b0;
      step();
      check("run_stays_done", ld_done, 1);
      check("run_stays_released", cpu_reset, 0);

      // Valid toggled every other cycle
      do_reset();
      start(3, 32'h12);
      for (int i = 0; i < 5; i++) begin
         if (i % 2 == 0) send(32'h5 + i / 2, 32'(4 * (i / 2)));
         else step();
      end
      step();
      check("t2_done", ld_done, 1);

      // Abort together with the second word
      do_reset();
      start(4, 32'h0);
      send(32'hA1, 32'h0);
      ld_valid = 1'b1; ld_data = 32'hA2; ld_abort = 1'b1;
      step();
      ld_valid = 1'b0; ld_abort = 1'b0;
      check("abort_ready", ld_ready, 0);
      check("abort_busy", ld_busy, 0);
      check("abort_done", ld_done, 0);
      start(1, 32'hB1);
      check("abort_restart_busy", ld_busy, 1);
      send(32'hB1, 32'h0);
      step();
      check("abort_restart_done", ld_done, 1);

      // Reset during a transfer cancels the write
      do_reset();
      start(2, 32'h0);
      ld_valid = 1'b1; ld_data = 32'hC1; reset = 1'b1;
      step();
      ld_valid = 1'b0; reset = 1'b0;
      check("rst_mid_busy", ld_busy, 0);
      check("rst_mid_cpu_reset", cpu_reset, 1);

      // Oversize length
      do_reset();
      ld_valid = 1'b1; ld_data = 32'hEE;
      start(MAX_WORDS + 1, 32'h0);
      step();
      step();
      ld_valid = 1'b0;
      check("over_error", ld_error, 1);
      check("over_cpu_reset", cpu_reset, 1);
      check("over_ready", ld_ready, 0);
      do_reset();
      check("over_rst_error", ld_error, 0);
      check("over_rst_cpu_reset", cpu_reset, 1);

      // Zero length goes straight to RUN
      start(0, 32'h0);
      check("zero_done", ld_done, 1);
      check("zero_cpu_reset", cpu_reset, 0);
      check("zero_busy", ld_busy, 0);

      // Exactly MAX_WORDS words
      do_reset();
      sum = 0;
      for (int i = 0; i < MAX_WORDS; i++) sum += 32'h100 + i;
      start(MAX_WORDS, sum);
      for (int i = 0; i < MAX_WORDS; i++) send(32'h100 + i, 32'(4 * i));
      step();
      check("max_done", ld_done, 1);
      check("max_error", ld_error, 0);

      // Checksum match and mismatch with words {1,2,3}
      do_reset();
      start(3, 32'd6);
      send(32'd1, 32'h0);
      send(32'd2, 32'h4);
      send(32'd3, 32'h8);
      step();
      check("csum_ok_done", ld_done, 1);
      check("csum_ok_error", ld_error, 0);
      do_reset();
      start(3, 32'd7);
      send(32'd1, 32'h0);
      send(32'd2, 32'h4);
      send(32'd3, 32'h8);
      step();
`ifdef RISCV_LOADER_CHECKSUM_EN
      check("csum_bad_error", ld_error, 1);
      check("csum_bad_done", ld_done, 0);
      check("csum_bad_cpu_reset", cpu_reset, 1);
`else
      check("csum_ignored_done", ld_done, 1);
      check("csum_ignored_error", ld_error, 0);
      check("csum_ignored_cpu_reset", cpu_reset, 0);
`endif

      step();
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
